// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between the requesters/FIFO side (master) and the write arbiter (slave).
// The arbiter sees the requests and FIFO status, and returns ready, write strobe/data and grant info.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DWIDTH = 32
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DWIDTH-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic [DWIDTH-1:0]       wr_data;
  logic                    wr_en;
  logic                    wr_full;
  logic                    gnt_valid;
  logic [IDW-1:0]          gnt_id;

  modport master (
    output req_valid, req_data, req_last, wr_full,
    input  req_ready, wr_data, wr_en, gnt_valid, gnt_id
  );

  modport slave (
    input  req_valid, req_data, req_last, wr_full,
    output req_ready, wr_data, wr_en, gnt_valid, gnt_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that merges N_REQ packet streams into one FIFO write port.
// Each grant lasts until a packet ends or MAX_BURST beats pass; every grant costs one IDLE cycle.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DWIDTH    = 32,
  parameter int MAX_BURST = 8
) (
  input logic               clk,
  input logic               rst,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state;
  state_t            next_state;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    gnt_id;
  logic [IDW-1:0]    sel_idx;
  logic [IDW-1:0]    sel_next;
  logic [IDW:0]      cand_w;
  logic              found;
  logic              any_valid;
  logic              accept;
  logic              end_grant;
  logic [CW-1:0]     beat_cnt;
  logic [N_REQ-1:0]  ready;
  logic [DWIDTH-1:0] data_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign data_arr[g] = bus.req_data[g*DWIDTH +: DWIDTH];
  end

  // Scan from rr_ptr upward with wraparound; the first valid requester wins.
  always_comb begin
    sel_idx = '0;
    found   = 1'b0;
    cand_w  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_w = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand_w >= (IDW+1)'(N_REQ)) begin
        cand_w = cand_w - (IDW+1)'(N_REQ);
      end
      if (!found && bus.req_valid[cand_w[IDW-1:0]]) begin
        found   = 1'b1;
        sel_idx = cand_w[IDW-1:0];
      end
    end
  end

  assign any_valid = |bus.req_valid;
  assign sel_next  = (sel_idx == IDW'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (any_valid) next_state = BUSY;
      BUSY: if (end_grant) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Ready and write strobe follow the held grant combinationally, so data passes with zero latency.
  always_comb begin
    ready = '0;
    if (state == BUSY && !bus.wr_full) begin
      ready[gnt_id] = 1'b1;
    end
    accept    = bus.req_valid[gnt_id] & ready[gnt_id];
    end_grant = accept && (bus.req_last[gnt_id] || beat_cnt == CW'(MAX_BURST - 1));
  end

  assign bus.req_ready = ready;
  assign bus.wr_en     = accept;
  assign bus.wr_data   = data_arr[gnt_id];
  assign bus.gnt_valid = (state == BUSY);
  assign bus.gnt_id    = gnt_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      gnt_id   <= '0;
      beat_cnt <= '0;
    end else if (state == IDLE) begin
      if (any_valid) begin
        gnt_id   <= sel_idx;
        rr_ptr   <= sel_next;
        beat_cnt <= '0;
      end
    end else if (accept) begin
      beat_cnt <= beat_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester packet queues drive the inputs,
// and a monitor checks every written beat (grant id and data) against an expected-beat queue.
module tb_fifo_wr_arbiter;
  localparam int N_REQ     = 4;
  localparam int DWIDTH    = 32;
  localparam int MAX_BURST = 8;
  localparam int IDW       = 2;

  typedef struct packed {
    logic [DWIDTH-1:0] data;
    logic              last;
    int                gap;
  } beat_t;

  typedef struct packed {
    logic [IDW-1:0]    id;
    logic [DWIDTH-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  fifo_wr_arbiter_if #(.N_REQ(N_REQ), .DWIDTH(DWIDTH)) bus ();

  fifo_wr_arbiter #(.N_REQ(N_REQ), .DWIDTH(DWIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  beat_t rq [N_REQ][$];
  exp_t  expq[$];
  int    beat_cycles[$];
  int    cycle  = 0;
  int    n_vec  = 0;
  int    n_miss = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cycle);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Requester model: a beat leaves its queue only after a handshake seen mid-cycle.
  initial begin
    logic [N_REQ-1:0] acc;
    beat_t b;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() == 0) begin
          bus.req_valid[i] = 1'b0;
          bus.req_last[i]  = 1'b0;
        end else begin
          b = rq[i][0];
          if (b.gap > 0) begin
            b.gap--;
            rq[i][0] = b;
            bus.req_valid[i] = 1'b0;
          end else begin
            bus.req_valid[i]                 = 1'b1;
            bus.req_data[i*DWIDTH +: DWIDTH] = b.data;
            bus.req_last[i]                  = b.last;
          end
        end
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      check_output("wr_en_in_reset", 32'(bus.wr_en), 32'd0);
    end else if (bus.wr_en) begin
      beat_cycles.push_back(cycle);
      if (expq.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("[TB] FAIL unexpected_beat: got id %0d data 0x%0h, want no beat", bus.gnt_id, bus.wr_data);
      end else begin
        e = expq.pop_front();
        check_output("beat_id", 32'(bus.gnt_id), 32'(e.id));
        check_output("beat_data", bus.wr_data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_packet(input int id, input logic [31:0] base, input int len,
                             input int gap_at, input int gap_len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = base + 32'(k);
      b.last = (k == len - 1);
      b.gap  = (k == gap_at) ? gap_len : 0;
      rq[id].push_back(b);
    end
  endtask

  task automatic expect_beats(input int id, input logic [31:0] base, input int count);
    exp_t e;
    for (int k = 0; k < count; k++) begin
      e.id   = IDW'(id);
      e.data = base + 32'(k);
      expq.push_back(e);
    end
  endtask

  task automatic wait_expq(input int target, input int limit);
    int n = 0;
    while (expq.size() != target && n < limit) begin
      tick();
      n++;
    end
    check_output("expq_level", 32'(expq.size()), 32'(target));
  endtask

  task automatic flush_all();
    expq.delete();
    for (int i = 0; i < N_REQ; i++) rq[i].delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_gnt_valid"}, 32'(bus.gnt_valid), 32'd0);
    check_output({tag, "_wr_en"},     32'(bus.wr_en),     32'd0);
    check_output({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    flush_all();
    #1;
    check_idle_outputs("reset");
    check_output("reset_gnt_id", 32'(bus.gnt_id), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    bus.wr_full = 1'b0;
    #1;
    check_idle_outputs("por");
    check_output("por_gnt_id", 32'(bus.gnt_id), 32'd0);

    // Single requester, 3-beat packet: one IDLE cycle, three back-to-back beats, one IDLE cycle.
    do_reset();
    load_packet(2, 32'hA0, 3, -1, 0);
    expect_beats(2, 32'hA0, 3);
    @(negedge clk);
    @(negedge clk);
    check_output("single_idle_first", 32'(bus.gnt_valid), 32'd0);
    @(negedge clk);
    check_output("single_gnt_valid", 32'(bus.gnt_valid), 32'd1);
    check_output("single_gnt_id", 32'(bus.gnt_id), 32'd2);
    check_output("single_beat0", 32'(bus.wr_en), 32'd1);
    @(negedge clk);
    check_output("single_beat1", 32'(bus.wr_en), 32'd1);
    @(negedge clk);
    check_output("single_beat2", 32'(bus.wr_en), 32'd1);
    @(negedge clk);
    check_output("single_idle_after", 32'(bus.gnt_valid), 32'd0);
    check_output("single_no_wr_after", 32'(bus.wr_en), 32'd0);
    wait_expq(0, 20);

    // Round robin with all four requesters holding 1-beat packets.
    do_reset();
    beat_cycles.delete();
    for (int i = 0; i < N_REQ; i++) begin
      load_packet(i, 32'h10 + 32'(i), 1, -1, 0);
      load_packet(i, 32'h20 + 32'(i), 1, -1, 0);
    end
    for (int i = 0; i < N_REQ; i++) expect_beats(i, 32'h10 + 32'(i), 1);
    for (int i = 0; i < N_REQ; i++) expect_beats(i, 32'h20 + 32'(i), 1);
    wait_expq(0, 100);
    check_output("rr_beat_count", 32'(beat_cycles.size()), 32'd8);
    for (int k = 1; k < beat_cycles.size(); k++) begin
      check_output("rr_beat_spacing", 32'(beat_cycles[k] - beat_cycles[k-1]), 32'd2);
    end

    // Burst cap: 20-beat packet from 1 interleaved with two 1-beat packets from 3.
    do_reset();
    load_packet(1, 32'h100, 20, -1, 0);
    load_packet(3, 32'h300, 1, -1, 0);
    load_packet(3, 32'h301, 1, -1, 0);
    expect_beats(1, 32'h100, 8);
    expect_beats(3, 32'h300, 1);
    expect_beats(1, 32'h108, 8);
    expect_beats(3, 32'h301, 1);
    expect_beats(1, 32'h110, 4);
    wait_expq(0, 200);

    // Backpressure: FIFO full for 5 cycles after the second beat of a 6-beat packet.
    do_reset();
    load_packet(0, 32'h400, 6, -1, 0);
    expect_beats(0, 32'h400, 6);
    wait_expq(4, 50);
    bus.wr_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_output("full_req_ready", 32'(bus.req_ready), 32'd0);
      check_output("full_wr_en", 32'(bus.wr_en), 32'd0);
      check_output("full_gnt_id", 32'(bus.gnt_id), 32'd0);
      check_output("full_gnt_valid", 32'(bus.gnt_valid), 32'd1);
    end
    tick();
    bus.wr_full = 1'b0;
    wait_expq(0, 50);

    // Valid gap: granted requester 0 idles 3 cycles mid-packet while 1 and 2 wait.
    do_reset();
    load_packet(0, 32'h500, 4, 2, 3);
    load_packet(1, 32'h510, 1, -1, 0);
    load_packet(2, 32'h520, 1, -1, 0);
    expect_beats(0, 32'h500, 4);
    expect_beats(1, 32'h510, 1);
    expect_beats(2, 32'h520, 1);
    wait_expq(4, 50);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_output("gap_wr_en", 32'(bus.wr_en), 32'd0);
      check_output("gap_gnt_valid", 32'(bus.gnt_valid), 32'd1);
      check_output("gap_gnt_id", 32'(bus.gnt_id), 32'd0);
    end
    wait_expq(0, 50);

    // Reset after beat 2 of 5 abandons the grant; arbitration restarts from index 0.
    do_reset();
    load_packet(0, 32'h600, 5, -1, 0);
    expect_beats(0, 32'h600, 5);
    wait_expq(3, 50);
    rst = 1'b1;
    #1;
    check_output("midrst_gnt_valid", 32'(bus.gnt_valid), 32'd0);
    check_output("midrst_wr_en", 32'(bus.wr_en), 32'd0);
    check_output("midrst_gnt_id", 32'(bus.gnt_id), 32'd0);
    flush_all();
    repeat (2) tick();
    rst = 1'b0;
    load_packet(1, 32'h610, 1, -1, 0);
    load_packet(3, 32'h630, 1, -1, 0);
    expect_beats(1, 32'h610, 1);
    expect_beats(3, 32'h630, 1);
    wait_expq(0, 50);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, legal range 2..16.
REQ-002 Parameter DWIDTH, default 32: data width of each beat.
REQ-003 Parameter MAX_BURST, default 8: maximum beats per grant, legal range 1..256.
REQ-004 Port clk, input, 1: single clock for all logic.
REQ-005 Port rst, input, 1: reset, asynchronous assert, active-high.
REQ-006 Port req_valid, input, N_REQ: bit i high means requester i presents a beat.
REQ-007 Port req_data, input, N_REQ*DWIDTH: requester i data is in bits [i*DWIDTH +: DWIDTH].
REQ-008 Port req_last, input, N_REQ: bit i marks the final beat of requester i's packet.
REQ-009 Port req_ready, output, N_REQ: bit i high means requester i's beat is accepted this cycle if valid.
REQ-010 Port wr_data, output, DWIDTH: beat to the FIFO write port.
REQ-011 Port wr_en, output, 1: FIFO write strobe.
REQ-012 Port wr_full, input, 1: FIFO full, including full-during-reset.
REQ-013 Port gnt_valid, output, 1: high while a grant is held (BUSY).
REQ-014 Port gnt_id, output, $clog2(N_REQ): index of the current or most recent grant.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and BUSY.
REQ-016 In IDLE with any req_valid set, the arbiter SHALL select the first set bit at or after rr_ptr, wrapping modulo N_REQ.
- Selection registers gnt_id and moves to BUSY on the next edge.
- IDLE costs one cycle; there is no combinational grant.
REQ-017 In IDLE with no req_valid set, the FSM SHALL stay in IDLE and hold gnt_id.
REQ-018 On entering BUSY, rr_ptr SHALL become (selected index + 1) mod N_REQ.
REQ-019 req_ready[i] SHALL equal (state==BUSY) & (gnt_id==i) & ~wr_full; all other ready bits SHALL be 0.
REQ-020 wr_en SHALL equal req_valid[gnt_id] & req_ready[gnt_id].
REQ-021 wr_data SHALL be req_data of gnt_id, combinational, with zero added latency.
REQ-022 A beat is accepted when wr_en is high; beat_cnt SHALL increment on each accepted beat and clear on entering BUSY.
REQ-023 BUSY SHALL return to IDLE on the edge after an accepted beat that either has req_last set or makes beat_cnt reach MAX_BURST.
- A truncated packet resumes at a later grant; the arbiter does not reorder or drop beats.
REQ-024 In BUSY, a beat is not accepted when wr_full is high or req_valid[gnt_id] is low; the grant SHALL then be held with no timeout.
REQ-025 gnt_valid SHALL equal (state==BUSY).
REQ-026 beat_cnt SHALL be wide enough to hold MAX_BURST, with no wrap inside a grant.
REQ-027 Requests arriving during BUSY SHALL have no effect until the next IDLE cycle.
REQ-028 Sustained throughput for one packet SHALL be 1 beat/cycle; each grant costs 1 idle cycle.

Reset
REQ-029 While rst is high, the block SHALL reset asynchronously to the following values:
- state IDLE, rr_ptr 0, gnt_id 0, beat_cnt 0;
- gnt_valid 0, req_ready all 0, wr_en 0.
REQ-030 Reset asserted mid-packet SHALL abandon the grant immediately; no wr_en SHALL occur during rst.
REQ-031 After rst deasserts, the first arbitration SHALL start from index 0.

Verification
REQ-032 Single requester: N_REQ=4, req_valid=0b0100, 3-beat packet D0..D2 with last on D2.
- gnt_id=2 one cycle after valid.
- wr_en high for 3 consecutive cycles with D0,D1,D2.
- Then one IDLE cycle.
REQ-033 Round robin: all four requesters hold 1-beat packets continuously.
- Grant order 0,1,2,3,0.
- One beat every 2 cycles.
REQ-034 Burst cap: MAX_BURST=8, requester 1 sends a 20-beat packet while requester 3 is also valid.
- Grants in order: 1 (8 beats), 3, 1 (8 beats), 3, 1 (4 beats).
REQ-035 Backpressure: wr_full held high for 5 cycles mid-packet.
- req_ready and wr_en low for those 5 cycles.
- gnt_id unchanged.
- No beat lost or duplicated after wr_full falls.
REQ-036 Valid gap: granted requester drops req_valid for 3 cycles mid-packet while others are valid.
- Grant held, no wr_en during the gap.
- Packet completes before another grant.
REQ-037 Reset mid-packet: rst pulsed after beat 2 of 5.
- gnt_valid=0 and wr_en=0 immediately.
- After release with req_valid=0b1010, the first grant is 1.
